// File: rtl/axi_loopback_chain.sv
// ---------------------------------------------------------------------------
// axi_loopback_chain
//
// Self-contained AXI4-Lite traffic chain:
//   master stimulus generator -> one-stage register slice (AW, W, B, AR, R)
//   -> slave memory model.
// On start the master writes NUM_TXN words (addr i*4, data A5A5_0000+i),
// reads them back through the same slice and scoreboards every readback.
//
// Ports:
//   aclk        in   clock, all logic on the rising edge
//   areset      in   asynchronous, active-high reset (released synchronously)
//   start       in   single-cycle request to begin a run (IDLE/DONE only)
//   addr_offset in   [ADDR_WIDTH-1:0] offset added to every master address
//                    (present only with AXI_CHAIN_RANGE_CHECK_EN)
//   busy        out  run in progress
//   done        out  run finished, held until next start or reset
//   pass        out  valid with done: no mismatches and all responses OKAY
//   err_count   out  [15:0] mismatches + non-OKAY responses, saturating
//   wr_count    out  [15:0] B handshakes seen by the master
//   rd_count    out  [15:0] R handshakes seen by the master
//
// Optional feature macro: AXI_CHAIN_RANGE_CHECK_EN
//   Defined  : slave answers SLVERR for addresses >= MEM_DEPTH*4 (no write,
//              reads return DEAD_BEEF) and the addr_offset port exists.
//   Undefined: addresses wrap modulo MEM_DEPTH*4, responses always OKAY.
//
// Handshake rule on every channel: a beat transfers in the cycle where
// VALID && READY; VALID never waits on READY and, once raised, is held with
// a stable payload until it transfers. READY may depend on VALID.
// ---------------------------------------------------------------------------
module axi_loopback_chain #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int NUM_TXN    = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
`ifdef AXI_CHAIN_RANGE_CHECK_EN
    input  logic [ADDR_WIDTH-1:0] addr_offset,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // -----------------------------------------------------------------------
    // Master-side channel signals (m_*) and slave-side channel signals (s_*)
    // -----------------------------------------------------------------------
    logic                  m_awvalid, m_awready;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [2:0]            m_awprot;
    logic                  m_wvalid, m_wready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [STRB_W-1:0]     m_wstrb;
    logic                  m_bvalid, m_bready;
    logic [1:0]            m_bresp;
    logic                  m_arvalid, m_arready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [2:0]            m_arprot;
    logic                  m_rvalid, m_rready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;

    logic                  s_awvalid, s_awready;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [2:0]            s_awprot;
    logic                  s_wvalid, s_wready;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [STRB_W-1:0]     s_wstrb;
    logic                  s_bvalid, s_bready;
    logic [1:0]            s_bresp;
    logic                  s_arvalid, s_arready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [2:0]            s_arprot;
    logic                  s_rvalid, s_rready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic [1:0]            s_rresp;

    // -----------------------------------------------------------------------
    // Master FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } master_state_e;

    // Flat debug view of the master's control registers.
    typedef struct packed {
        master_state_e state;
        logic [15:0]   idx;
    } master_dbg_t;

    master_state_e state_q, state_d;
    logic [15:0]   idx_q;
    logic          aw_sent_q, w_sent_q;
    logic [15:0]   err_q, wr_q, rd_q;
    master_dbg_t   dbg;

    assign dbg.state = state_q;
    assign dbg.idx   = idx_q;

    logic                  last_txn;
    logic                  run_start;
    logic                  aw_fire, w_fire, b_fire, r_fire;
    logic                  err_inc;
    logic [ADDR_WIDTH-1:0] txn_addr;
    logic [DATA_WIDTH-1:0] txn_data;

    assign last_txn  = (dbg.idx == 16'(NUM_TXN - 1));
    assign run_start = start && ((dbg.state == ST_IDLE) || (dbg.state == ST_DONE));
    assign txn_data  = 32'hA5A5_0000 + {16'h0000, dbg.idx};

`ifdef AXI_CHAIN_RANGE_CHECK_EN
    assign txn_addr = ADDR_WIDTH'({dbg.idx, 2'b00}) + addr_offset;
`else
    assign txn_addr = ADDR_WIDTH'({dbg.idx, 2'b00});
`endif

    // Payload depends only on idx_q, which is frozen while a request is
    // pending, so it stays stable until the handshake.
    assign m_awaddr = txn_addr;
    assign m_awprot = 3'b000;
    assign m_wdata  = txn_data;
    assign m_wstrb  = '1;
    assign m_araddr = txn_addr;
    assign m_arprot = 3'b000;

    assign aw_fire = m_awvalid && m_awready;
    assign w_fire  = m_wvalid && m_wready;
    assign b_fire  = m_bvalid && m_bready;
    assign r_fire  = m_rvalid && m_rready;

    assign err_inc = (b_fire && (m_bresp != RESP_OKAY)) ||
                     (r_fire && ((m_rdata != txn_data) || (m_rresp != RESP_OKAY)));

    always_comb begin
        state_d   = state_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                // AW and W go out together; each drops once it has been taken.
                m_awvalid = !aw_sent_q;
                m_wvalid  = !w_sent_q;
                if ((aw_sent_q || m_awready) && (w_sent_q || m_wready))
                    state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = last_txn ? ST_RD_REQ : ST_WR_REQ;
            end
            ST_RD_REQ: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                m_rready = 1'b1;
                if (m_rvalid) state_d = last_txn ? ST_DONE : ST_RD_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
            err_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q <= state_d;
            // Sent flags only live while the master stays in WR_REQ.
            aw_sent_q <= (state_q == ST_WR_REQ) && (state_d == ST_WR_REQ) && (aw_sent_q || aw_fire);
            w_sent_q  <= (state_q == ST_WR_REQ) && (state_d == ST_WR_REQ) && (w_sent_q || w_fire);
            if (run_start) begin
                idx_q <= '0;
                err_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
            end else begin
                if (b_fire) wr_q <= wr_q + 16'd1;
                if (r_fire) rd_q <= rd_q + 16'd1;
                if (b_fire || r_fire) idx_q <= last_txn ? 16'd0 : idx_q + 16'd1;
                if (err_inc && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
            end
        end
    end

    assign busy      = (dbg.state != ST_IDLE) && (dbg.state != ST_DONE);
    assign done      = (dbg.state == ST_DONE);
    assign pass      = done && (err_q == 16'd0);
    assign err_count = err_q;
    assign wr_count  = wr_q;
    assign rd_count  = rd_q;

    // -----------------------------------------------------------------------
    // Passthrough: one register stage per channel. READY = !full, payload is
    // presented the cycle after capture, and the stage can refill only the
    // cycle after it empties.
    // -----------------------------------------------------------------------
    logic                  aw_full;
    logic [ADDR_WIDTH+2:0] aw_buf;
    assign m_awready             = !aw_full;
    assign s_awvalid             = aw_full;
    assign {s_awaddr, s_awprot}  = aw_buf;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_full <= 1'b0;
            aw_buf  <= '0;
        end else if (m_awvalid && !aw_full) begin
            aw_full <= 1'b1;
            aw_buf  <= {m_awaddr, m_awprot};
        end else if (aw_full && s_awready) begin
            aw_full <= 1'b0;
        end
    end

    logic                         w_full;
    logic [DATA_WIDTH+STRB_W-1:0] w_buf;
    assign m_wready           = !w_full;
    assign s_wvalid           = w_full;
    assign {s_wdata, s_wstrb} = w_buf;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_full <= 1'b0;
            w_buf  <= '0;
        end else if (m_wvalid && !w_full) begin
            w_full <= 1'b1;
            w_buf  <= {m_wdata, m_wstrb};
        end else if (w_full && s_wready) begin
            w_full <= 1'b0;
        end
    end

    logic       b_full;
    logic [1:0] b_buf;
    assign s_bready = !b_full;
    assign m_bvalid = b_full;
    assign m_bresp  = b_buf;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            b_full <= 1'b0;
            b_buf  <= '0;
        end else if (s_bvalid && !b_full) begin
            b_full <= 1'b1;
            b_buf  <= s_bresp;
        end else if (b_full && m_bready) begin
            b_full <= 1'b0;
        end
    end

    logic                  ar_full;
    logic [ADDR_WIDTH+2:0] ar_buf;
    assign m_arready            = !ar_full;
    assign s_arvalid            = ar_full;
    assign {s_araddr, s_arprot} = ar_buf;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_full <= 1'b0;
            ar_buf  <= '0;
        end else if (m_arvalid && !ar_full) begin
            ar_full <= 1'b1;
            ar_buf  <= {m_araddr, m_arprot};
        end else if (ar_full && s_arready) begin
            ar_full <= 1'b0;
        end
    end

    logic                  r_full;
    logic [DATA_WIDTH+1:0] r_buf;
    assign s_rready           = !r_full;
    assign m_rvalid           = r_full;
    assign {m_rdata, m_rresp} = r_buf;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_full <= 1'b0;
            r_buf  <= '0;
        end else if (s_rvalid && !r_full) begin
            r_full <= 1'b1;
            r_buf  <= {s_rdata, s_rresp};
        end else if (r_full && m_rready) begin
            r_full <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Slave memory model: one outstanding write and one outstanding read.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_ok, rd_ok;
    logic                  slv_wr_fire, slv_rd_fire;

    assign wr_idx = s_awaddr[IDX_W+1:2];
    assign rd_idx = s_araddr[IDX_W+1:2];

`ifdef AXI_CHAIN_RANGE_CHECK_EN
    assign wr_ok = (32'(s_awaddr) < 32'(MEM_DEPTH * 4));
    assign rd_ok = (32'(s_araddr) < 32'(MEM_DEPTH * 4));
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif

    // AW and W are only taken together, and only with no B pending.
    assign slv_wr_fire = s_awvalid && s_wvalid && !s_bvalid;
    assign s_awready   = slv_wr_fire;
    assign s_wready    = slv_wr_fire;

    assign s_arready   = !s_rvalid;
    assign slv_rd_fire = s_arvalid && s_arready;

    // Memory contents survive reset.
    always_ff @(posedge aclk) begin
        if (slv_wr_fire && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) mem[wr_idx][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else if (slv_wr_fire) begin
            s_bvalid <= 1'b1;
            s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_bvalid && s_bready) begin
            s_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (slv_rd_fire) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_ok ? mem[rd_idx] : 32'hDEAD_BEEF;
            s_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    // PROT is carried end to end but has no meaning to this memory; the byte
    // offset and (without range checking) the upper address bits are ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, s_awprot, s_arprot, s_awaddr, s_araddr};

endmodule

// File: tb/tb_axi_loopback_chain.sv
// ---------------------------------------------------------------------------
// tb_axi_loopback_chain
//
// Drives axi_loopback_chain with start/reset only. A table of run scenarios
// (idle gap, stray start pulses while busy, backdoor corruption of one
// memory word, address offset) is applied in a loop, followed by a mid-run
// reset sequence and a set of randomized runs. A reference model computes
// the expected readback stream and error total from the traffic rules.
// Expected readbacks sit in exp_q and are matched against every R
// handshake seen at the master.
// ---------------------------------------------------------------------------
module tb_axi_loopback_chain;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 256;
  localparam int NUM_TXN    = 16;
  // Per transaction: master->slice, slice->slave, slave->slice, slice->master.
  localparam int RUN_CYCLES = 8 * NUM_TXN;
  localparam int BUDGET     = 400;

  logic        aclk, areset, start;
  logic        busy, done, pass;
  logic [15:0] err_count, wr_count, rd_count;
`ifdef AXI_CHAIN_RANGE_CHECK_EN
  logic [ADDR_WIDTH-1:0] addr_offset;
`endif

  int n_cmp;
  int n_bad;
  logic [DATA_WIDTH-1:0] exp_q[$];

  typedef struct {
    int          gap;
    int          n_spur;
    bit          do_corrupt;
    int          cw;
    logic [31:0] cval;
    logic [11:0] off;
    bit          exp_pass;
    int          exp_err;
  } vec_t;

  vec_t vecs[$];

  axi_loopback_chain #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .NUM_TXN   (NUM_TXN)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
`ifdef AXI_CHAIN_RANGE_CHECK_EN
    .addr_offset(addr_offset),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit out_of_range(int a);
`ifdef AXI_CHAIN_RANGE_CHECK_EN
    return a >= MEM_DEPTH * 4;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: replay the run on a plain word array, apply the
  // backdoor corruption, fill exp_q with the readbacks and return the
  // expected error total (bad responses plus data mismatches).
  function automatic int build_model(bit do_corrupt, int cw, logic [31:0] cval, logic [11:0] off);
    logic [31:0] mm [MEM_DEPTH];
    logic [31:0] v;
    int err;
    int a;
    err = 0;
    exp_q.delete();
    foreach (mm[k]) mm[k] = 32'h0;
    for (int i = 0; i < NUM_TXN; i++) begin
      a = (i * 4 + int'(off)) % (1 << ADDR_WIDTH);
      if (out_of_range(a)) err++;
      else mm[(a / 4) % MEM_DEPTH] = 32'hA5A5_0000 + i;
    end
    if (do_corrupt) mm[cw] = cval;
    for (int i = 0; i < NUM_TXN; i++) begin
      a = (i * 4 + int'(off)) % (1 << ADDR_WIDTH);
      if (out_of_range(a)) begin
        exp_q.push_back(32'hDEAD_BEEF);
        err++;
      end else begin
        v = mm[(a / 4) % MEM_DEPTH];
        exp_q.push_back(v);
        if (v != 32'hA5A5_0000 + i) err++;
      end
    end
    return err;
  endfunction

  // ---------------- drivers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit spur [BUDGET];
    int cyc;
    int ridx;
    bit corrupted;
    void'(build_model(v.do_corrupt, v.cw, v.cval, v.off));
    foreach (spur[k]) spur[k] = 1'b0;
    for (int k = 0; k < v.n_spur; k++) spur[$urandom_range(2, RUN_CYCLES - 20)] = 1'b1;
`ifdef AXI_CHAIN_RANGE_CHECK_EN
    addr_offset = v.off;
`endif
    repeat (v.gap) @(negedge aclk);
    pulse_start();
    check($sformatf("%s:counts_cleared", tag), 64'({wr_count, rd_count, err_count}), 64'h0);
    check($sformatf("%s:busy_after_start", tag), 64'({busy, done, pass}), 64'b100);
    cyc = 0;
    ridx = 0;
    corrupted = 1'b0;
    while (!done && cyc < BUDGET) begin
      if (dut.m_rvalid && dut.m_rready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s:extra_readback: actual=%0h required=none", tag, dut.m_rdata);
        end else begin
          check($sformatf("%s:rdata[%0d]", tag, ridx), 64'(dut.m_rdata), 64'(exp_q.pop_front()));
        end
        ridx++;
      end
      if (v.do_corrupt && !corrupted && wr_count == 16'(NUM_TXN)) begin
        dut.mem[v.cw] <= v.cval;
        corrupted = 1'b1;
      end
      start = spur[cyc];
      @(negedge aclk);
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s:done", tag), 64'(done), 64'd1);
    check($sformatf("%s:run_cycles", tag), 64'(cyc), 64'(RUN_CYCLES));
    check($sformatf("%s:busy_at_done", tag), 64'(busy), 64'd0);
    check($sformatf("%s:pass", tag), 64'(pass), 64'(v.exp_pass));
    check($sformatf("%s:err_count", tag), 64'(err_count), 64'(v.exp_err));
    check($sformatf("%s:wr_count", tag), 64'(wr_count), 64'(NUM_TXN));
    check($sformatf("%s:rd_count", tag), 64'(rd_count), 64'(NUM_TXN));
    check($sformatf("%s:readbacks_left", tag), 64'(exp_q.size()), 64'd0);
    @(negedge aclk);
    check($sformatf("%s:done_held", tag), 64'({done, wr_count}), 64'({1'b1, 16'(NUM_TXN)}));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    int cyc;
    n_cmp  = 0;
    n_bad  = 0;
    start  = 1'b0;
    areset = 1'b1;
`ifdef AXI_CHAIN_RANGE_CHECK_EN
    addr_offset = '0;
`endif
    repeat (3) @(negedge aclk);
    check("reset:flags", 64'({busy, done, pass}), 64'h0);
    check("reset:counts", 64'({wr_count, rd_count, err_count}), 64'h0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle_after_release", 64'({busy, done, pass, wr_count}), 64'h0);

    // gap, n_spur, corrupt, word, value, offset, exp_pass, exp_err
    vecs.push_back('{2, 0, 1'b0, 0, 32'h0,          12'h000, 1'b1, 0});
    vecs.push_back('{0, 0, 1'b0, 0, 32'h0,          12'h000, 1'b1, 0});
    vecs.push_back('{1, 6, 1'b0, 0, 32'h0,          12'h000, 1'b1, 0});
    vecs.push_back('{3, 0, 1'b1, 3, 32'h0BAD_F00D,  12'h000, 1'b0, 1});
    vecs.push_back('{0, 0, 1'b0, 0, 32'h0,          12'h000, 1'b1, 0});
`ifdef AXI_CHAIN_RANGE_CHECK_EN
    vecs.push_back('{1, 0, 1'b0, 0, 32'h0,          12'h3F0, 1'b0, 24});
    vecs.push_back('{0, 0, 1'b0, 0, 32'h0,          12'h000, 1'b1, 0});
`endif
    for (int k = 0; k < vecs.size(); k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Mid-run reset once five writes have completed.
    pulse_start();
    cyc = 0;
    while (wr_count != 16'd5 && cyc < BUDGET) begin
      @(negedge aclk);
      cyc++;
    end
    check("midreset:reached_wr5", 64'(wr_count), 64'd5);
    #2 areset = 1'b1;
    #1;
    check("midreset:flags", 64'({busy, done, pass}), 64'h0);
    check("midreset:counts", 64'({wr_count, rd_count, err_count}), 64'h0);
    check("midreset:valids", 64'({dut.m_awvalid, dut.m_wvalid, dut.m_arvalid, dut.m_bvalid,
                                  dut.m_rvalid, dut.s_awvalid, dut.s_wvalid, dut.s_arvalid,
                                  dut.s_bvalid, dut.s_rvalid}), 64'h0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    check("midreset:idle_after_release", 64'({busy, done, wr_count}), 64'h0);
    run_vec("after_reset", '{1, 0, 1'b0, 0, 32'h0, 12'h000, 1'b1, 0});

    // Randomized runs with expectations from the reference model.
    for (int r = 0; r < 6; r++) begin
      rv.gap        = $urandom_range(0, 4);
      rv.n_spur     = $urandom_range(0, 4);
      rv.do_corrupt = 1'($urandom_range(0, 1));
      rv.cw         = $urandom_range(0, NUM_TXN - 1);
      rv.cval       = $urandom;
      rv.off        = 12'h000;
      rv.exp_err    = build_model(rv.do_corrupt, rv.cw, rv.cval, rv.off);
      rv.exp_pass   = (rv.exp_err == 0);
      run_vec($sformatf("rand%0d", r), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_loopback_chain.md
Name: axi_loopback_chain

Overview:
- Self-contained AXI4-Lite traffic chain: master stimulus generator -> one-stage passthrough register slice -> slave memory model.
- On start, the master writes NUM_TXN words, reads them back through the passthrough, and scoreboards each readback.
- It then reports done/pass and transaction counts.
- Sits at the top of the example simulation as the single DUT driven only by clock, reset and start.

Parameters:
- ADDR_WIDTH, 12, byte address width of internal AXI-Lite bus
- DATA_WIDTH, 32, data width, fixed at 32 (WSTRB = 4 bits)
- MEM_DEPTH, 256, words in slave memory, power of two
- NUM_TXN, 16, writes (and reads) per run, 1..MEM_DEPTH

Ports:
- aclk  in  1  clock, all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a run
- busy  out  1  run in progress
- done  out  1  run finished, held until next start or reset
- pass  out  1  valid when done: all readbacks matched and all responses OKAY
- err_count  out  16  readback mismatches plus non-OKAY responses, saturating
- wr_count  out  16  completed write transactions (B handshakes at master)
- rd_count  out  16  completed read transactions (R handshakes at master)

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE.
  - All VALID/READY low.
  - busy=done=pass=0; err_count=wr_count=rd_count=0.
  - Memory contents not reset.
- Master FSM states:
  - IDLE -> WR_REQ on start.
  - WR_REQ: drive AW/W.
  - WR_RESP: wait B, i++.
  - If i<NUM_TXN, return to WR_REQ; else go to RD_REQ with i=0.
  - RD_REQ -> RD_RESP: wait R, compare, i++.
  - RD_RESP -> RD_REQ while i<NUM_TXN, else DONE.
- DONE:
  - done=1; pass=(err_count==0).
  - start restarts the run: counters cleared, done=0 next cycle.
  - start in any state other than IDLE/DONE is ignored.
- Transaction i (0-based):
  - Address = i*4.
  - Write data = 32'hA5A5_0000 + i.
  - WSTRB = 4'hF; AWPROT = ARPROT = 0.
  - Expected readback = same value.
- Handshake rules on all channels:
  - Transfer when VALID && READY.
  - VALID, once high, stays high with stable payload until transfer.
  - VALID never waits on READY.
  - Master issues AW and W in the same cycle; keeps BREADY=1 and RREADY=1 in response states.
- Passthrough:
  - Single-entry register slice per channel (AW, W, B, AR, R).
  - Accepts when empty (READY = !full); presents the payload the next cycle.
  - Frees on downstream handshake; accepts again the cycle after.
  - Adds exactly 1 cycle latency per direction; no reordering.
- Slave memory:
  - Accepts AW and W only when both are valid (same-cycle handshake).
  - Writes bytes per WSTRB at word index addr[log2(MEM_DEPTH)+1:2] (address wraps modulo MEM_DEPTH*4).
  - Asserts BVALID the next cycle, BRESP=OKAY.
  - AR accepted when no R pending; RVALID next cycle with RDATA=mem[idx], RRESP=OKAY.
  - Only one outstanding transaction per direction.
- Scoreboard: on each R handshake, err_count increments if RDATA != expected or RRESP != OKAY. BRESP != OKAY also increments it. Saturates at 16'hFFFF.
- Counters increment on master-side B/R handshakes only.
- Reset mid-run aborts immediately to the reset values; in-flight transactions are discarded in every stage.

Optional Feature:
Macro AXI_CHAIN_RANGE_CHECK_EN.
- Defined:
  - The slave returns SLVERR (2'b10) for any address >= MEM_DEPTH*4 and does not write memory.
  - Reads of such addresses return RDATA=32'hDEAD_BEEF with SLVERR.
  - An extra input, addr_offset[ADDR_WIDTH-1:0], is added to all master addresses, to exercise this path.
- Undefined: addresses wrap silently, responses are always OKAY, and there is no addr_offset port.

Test Plan:
- Reset, pulse start, NUM_TXN=16 -> done=1 within 200 cycles; pass=1, err_count=0, wr_count=16, rd_count=16.
- Pulse start again after done -> counters cleared the cycle after start; second run also passes with counts 16/16.
- Assert areset when wr_count=5 -> all outputs 0 asynchronously; all VALIDs low. After release plus start, full run passes.
- Force a mismatch by corrupting mem word 3 via a backdoor write between phases -> pass=0, err_count=1, rd_count=16.
- Start pulses while busy -> no effect; the run completes with counts 16/16.
- With AXI_CHAIN_RANGE_CHECK_EN, MEM_DEPTH=256, addr_offset=12'h3F0 -> words 4..15 get SLVERR; err_count=24, pass=0.
